// File: rtl/daq_pkg.sv
// Shared constants and types for the event readout path.
package daq_pkg;

  localparam int unsigned N_CH      = 16;
  localparam int unsigned SAMPLE_W  = 64;
  localparam int unsigned TS_W      = 32;
  localparam int unsigned IDX_W     = $clog2(N_CH);
  localparam logic [15:0] HDR_MAGIC = 16'hA5A5;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    TSTAMP,
    DATA,
    ACK,
    RELEASE
  } state_t;

  typedef logic [N_CH-1:0][SAMPLE_W-1:0] event_t;

  // Header word layout, MSB first.
  typedef struct packed {
    logic [15:0] magic;
    logic [15:0] hit_mask;
    logic [31:0] event_id;
  } hdr_t;

  // One bit per channel: set when the channel word is nonzero.
  function automatic logic [N_CH-1:0] hit_mask_of(input event_t ev);
    logic [N_CH-1:0] m;
    m = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      m[IDX_W'(c)] = |ev[IDX_W'(c)];
    end
    return m;
  endfunction

endpackage

// File: rtl/event_packer_if.sv
// Sampler handoff plus outgoing AXI-Stream, as seen by the packer (master)
// and by whatever sits on the far side (slave).
interface event_packer_if;
  import daq_pkg::*;

  logic                evento_valid;
  event_t              evento;
  logic                event_saved;
  logic [SAMPLE_W-1:0] m_tdata;
  logic                m_tvalid;
  logic                m_tready;
  logic                m_tlast;

  modport master (
    input  evento_valid, evento, m_tready,
    output event_saved, m_tdata, m_tvalid, m_tlast
  );

  modport slave (
    output evento_valid, evento, m_tready,
    input  event_saved, m_tdata, m_tvalid, m_tlast
  );

endinterface

// File: rtl/next_hit_finder.sv
// Combinational search for the lowest set bit of mask at or above start.
// none_left is raised when no such bit exists (including start >= N_CH).
module next_hit_finder
  import daq_pkg::*;
(
  input  logic [N_CH-1:0]  mask,
  input  logic [IDX_W:0]   start,
  output logic [IDX_W-1:0] next_idx,
  output logic             none_left
);

  logic found;

  // Priority scan from channel 0 upward; first qualifying bit wins.
  always_comb begin
    found    = 1'b0;
    next_idx = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (!found && mask[IDX_W'(c)] && ((IDX_W+1)'(c) >= start)) begin
        found    = 1'b1;
        next_idx = IDX_W'(c);
      end
    end
    none_left = ~found;
  end

endmodule

// File: rtl/event_packer.sv
// Serialises a latched 16x64 event snapshot into a framed AXI-Stream:
// header, timestamp, then channel words. Returns event_saved to the sampler
// once the last beat has been accepted.
// Build option: EVENT_PACKER_ZERO_SUPPRESS_EN sends only nonzero channels.
// Without it the channel search runs over an all-ones mask, so every channel
// is sent in order.
module event_packer
  import daq_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  event_packer_if.master bus,
  output logic           busy,
  output logic [31:0]    event_count
);

  state_t              state, state_d;
  logic [TS_W-1:0]     ts_cnt, ts_lat;
  event_t              snap;
  logic [IDX_W-1:0]    cur_idx, cur_idx_d;
  logic [N_CH-1:0]     cap_mask, find_mask;
  logic [IDX_W:0]      find_start;
  logic [IDX_W-1:0]    found_idx;
  logic                none_left;
  hdr_t                hdr_w;
  logic                fire, capture;
  logic [SAMPLE_W-1:0] tdata_d;
  logic                tvalid_d, tlast_d, saved_d, busy_d;
  logic [31:0]         count_d;

`ifdef EVENT_PACKER_ZERO_SUPPRESS_EN
  logic [N_CH-1:0] hit_mask_q;

  // Hit mask of the frame in flight drives the channel search.
  always_ff @(posedge clk) begin
    if (reset)        hit_mask_q <= '0;
    else if (capture) hit_mask_q <= cap_mask;
  end

  assign find_mask = hit_mask_q;
`else
  assign find_mask = '1;
`endif

  assign fire     = bus.m_tvalid & bus.m_tready;
  assign cap_mask = hit_mask_of(bus.evento);
  assign hdr_w    = '{magic: HDR_MAGIC, hit_mask: cap_mask, event_id: event_count};

  // The header beat looks for the first channel; later beats look past the
  // channel currently being loaded.
  assign find_start = (state == HEADER) ? '0
                    : (IDX_W+1)'(cur_idx) + (IDX_W+1)'(1);

  next_hit_finder u_finder (
    .mask      (find_mask),
    .start     (find_start),
    .next_idx  (found_idx),
    .none_left (none_left)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:         if (bus.evento_valid) state_d = HEADER;
      HEADER:       if (fire) state_d = TSTAMP;
      TSTAMP, DATA: if (fire) state_d = bus.m_tlast ? ACK : DATA;
      ACK:          state_d = RELEASE;
      RELEASE:      if (!bus.evento_valid) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs and the channel pointer.
  // Each transfer loads the following word so the stream has no bubbles.
  always_comb begin
    tdata_d   = bus.m_tdata;
    tvalid_d  = bus.m_tvalid;
    tlast_d   = bus.m_tlast;
    saved_d   = 1'b0;
    count_d   = event_count;
    cur_idx_d = cur_idx;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.evento_valid) begin
          capture  = 1'b1;
          tdata_d  = hdr_w;
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
        end
      end
      HEADER: begin
        if (fire) begin
          tdata_d   = SAMPLE_W'(ts_lat);
          tlast_d   = none_left;
          cur_idx_d = found_idx;
        end
      end
      TSTAMP, DATA: begin
        if (fire) begin
          if (bus.m_tlast) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            saved_d  = 1'b1;
            count_d  = event_count + 32'd1;
          end else begin
            tdata_d   = snap[cur_idx];
            tlast_d   = none_left;
            cur_idx_d = found_idx;
          end
        end
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Output, snapshot and timestamp registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_cnt          <= '0;
      ts_lat          <= '0;
      snap            <= '0;
      cur_idx         <= '0;
      bus.m_tdata     <= '0;
      bus.m_tvalid    <= 1'b0;
      bus.m_tlast     <= 1'b0;
      bus.event_saved <= 1'b0;
      event_count     <= '0;
      busy            <= 1'b0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      if (capture) begin
        snap   <= bus.evento;
        ts_lat <= ts_cnt;
      end
      cur_idx         <= cur_idx_d;
      bus.m_tdata     <= tdata_d;
      bus.m_tvalid    <= tvalid_d;
      bus.m_tlast     <= tlast_d;
      bus.event_saved <= saved_d;
      event_count     <= count_d;
      busy            <= busy_d;
    end
  end

endmodule

// File: tb/tb_event_packer.sv
// Self-checking bench for event_packer: a vector table of frame patterns,
// hand-written sequences for hold/release, timestamp spacing and mid-frame
// reset, then randomized events against a frame-level reference model.
module tb_event_packer;
  import daq_pkg::*;

`ifdef EVENT_PACKER_ZERO_SUPPRESS_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        busy;
  logic [31:0] event_count;

  event_packer_if pk_if();

  event_packer dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (pk_if),
    .busy        (busy),
    .event_count (event_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] tb_cycles;
  logic [31:0] exp_count;
  logic [63:0] exp_d[$];
  logic [63:0] got_d[$];
  bit          exp_l[$];
  bit          got_l[$];

  typedef struct {
    logic [63:0] base;
    logic [15:0] nz;
    int          rmode;
    int          beats_full;
    int          beats_zs;
  } vec_t;

  vec_t vt[6];

  // Elapsed cycles since reset: the value the timestamp must report.
  always @(posedge clk) begin
    if (reset) tb_cycles <= '0;
    else       tb_cycles <= tb_cycles + 32'd1;
  end

  initial begin
    #2_000_000;
    $fatal(1, "FAIL watchdog: simulation time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic event_t make_ev(input logic [63:0] base, input logic [15:0] nz);
    event_t ev;
    for (int c = 0; c < 16; c++) ev[c] = nz[c] ? base + 64'(c) : 64'h0;
    return ev;
  endfunction

  function automatic event_t rand_ev(input bit all_zero);
    event_t ev;
    for (int c = 0; c < 16; c++) begin
      if (!all_zero && ($urandom_range(0, 1) == 1)) ev[c] = {$urandom, $urandom} | 64'h1;
      else ev[c] = 64'h0;
    end
    return ev;
  endfunction

  // Expected frame: header, timestamp, then every channel (or only nonzero
  // channels when zero suppression is built in); last flag on final word.
  task automatic build_expected(input event_t ev, input logic [31:0] ts, input logic [31:0] id);
    logic [15:0] hit;
    exp_d.delete();
    exp_l.delete();
    for (int c = 0; c < 16; c++) hit[c] = (ev[c] != 64'h0);
    exp_d.push_back({16'hA5A5, hit, id});
    exp_l.push_back(1'b0);
    exp_d.push_back({32'h0, ts});
    exp_l.push_back(1'b0);
    for (int c = 0; c < 16; c++) begin
      if (!ZS || hit[c]) begin
        exp_d.push_back(ev[c]);
        exp_l.push_back(1'b0);
      end
    end
    exp_l[exp_l.size() - 1] = 1'b1;
  endtask

  // Collect one frame; returns at the sample point where the last beat is
  // being presented with m_tready=1 (it transfers on the next edge).
  task automatic recv_frame(input int rmode);
    bit          done;
    bit          early_saved;
    bit          prev_stall;
    logic [63:0] prev_d;
    bit          prev_l;
    done        = 1'b0;
    early_saved = 1'b0;
    prev_stall  = 1'b0;
    prev_d      = '0;
    prev_l      = 1'b0;
    got_d.delete();
    got_l.delete();
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      case (rmode)
        0:       pk_if.m_tready = 1'b1;
        1:       pk_if.m_tready = (cyc % 2 == 0);
        default: pk_if.m_tready = ($urandom_range(0, 2) != 0);
      endcase
      if (cyc == 3) pk_if.evento = rand_ev(1'b0);
      if (pk_if.event_saved) early_saved = 1'b1;
      if (prev_stall) begin
        check("hold_valid", 64'(pk_if.m_tvalid), 64'(1));
        check("hold_data", pk_if.m_tdata, prev_d);
        check("hold_last", 64'(pk_if.m_tlast), 64'(prev_l));
      end
      if (pk_if.m_tvalid && pk_if.m_tready) begin
        if (got_d.size() == 0) check("busy_in_frame", 64'(busy), 64'(1));
        got_d.push_back(pk_if.m_tdata);
        got_l.push_back(pk_if.m_tlast);
        if (pk_if.m_tlast) done = 1'b1;
      end
      prev_stall = pk_if.m_tvalid && !pk_if.m_tready;
      prev_d     = pk_if.m_tdata;
      prev_l     = pk_if.m_tlast;
      if (!done) tick();
    end
    check("frame_done", 64'(done), 64'(1));
    check("no_early_saved", 64'(early_saved), 64'(0));
  endtask

  // Present an event from IDLE, receive and score the frame, then release.
  task automatic run_frame(input event_t ev, input int rmode, input bit hold_after);
    int bad;
    pk_if.evento       = ev;
    pk_if.evento_valid = 1'b1;
    build_expected(ev, tb_cycles, exp_count);
    recv_frame(rmode);
    check("beat_count", 64'(got_d.size()), 64'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      check("word", got_d[i], exp_d[i]);
      check("last", 64'(got_l[i]), 64'(exp_l[i]));
    end
    tick();
    pk_if.m_tready = 1'b0;
    check("saved_pulse", 64'(pk_if.event_saved), 64'(1));
    check("tvalid_after", 64'(pk_if.m_tvalid), 64'(0));
    exp_count = exp_count + 32'd1;
    check("event_count", 64'(event_count), 64'(exp_count));
    if (hold_after) begin
      bad = 0;
      pk_if.m_tready = 1'b1;
      for (int k = 0; k < 20; k++) begin
        tick();
        if (pk_if.m_tvalid || pk_if.event_saved) bad++;
      end
      pk_if.m_tready = 1'b0;
      check("no_refire", 64'(bad), 64'(0));
      check("busy_hold", 64'(busy), 64'(1));
    end
    pk_if.evento_valid = 1'b0;
    tick();
    check("saved_once", 64'(pk_if.event_saved), 64'(0));
    tick();
    check("idle_busy", 64'(busy), 64'(0));
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    pk_if.evento_valid = 1'b0;
    pk_if.m_tready     = 1'b0;
    tick();
    tick();
    check("rst_tvalid", 64'(pk_if.m_tvalid), 64'(0));
    check("rst_tlast", 64'(pk_if.m_tlast), 64'(0));
    check("rst_tdata", pk_if.m_tdata, 64'(0));
    check("rst_saved", 64'(pk_if.event_saved), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_count", 64'(event_count), 64'(0));
    reset     = 1'b0;
    exp_count = '0;
  endtask

  initial begin
    logic [31:0] ts1;
    logic [31:0] ts2;
    int          nb;
    bit          reached;
    int          exp_beats;

    vt[0] = '{64'h1000,      16'hFFFF, 0, 18, 18};
    vt[1] = '{64'h1000,      16'hFFFF, 1, 18, 18};
    vt[2] = '{64'hDEAD_0000, 16'h1008, 0, 18, 4};
    vt[3] = '{64'h5000,      16'h0000, 1, 18, 2};
    vt[4] = '{64'h7700_0000, 16'h8000, 2, 18, 3};
    vt[5] = '{64'h0BEE_0000, 16'h0001, 0, 18, 3};

    reset              = 1'b1;
    pk_if.evento       = '0;
    pk_if.evento_valid = 1'b0;
    pk_if.m_tready     = 1'b0;
    exp_count          = '0;
    do_reset();

    // Table-driven frames; the first one starts straight out of reset.
    for (int i = 0; i < 6; i++) begin
      run_frame(make_ev(vt[i].base, vt[i].nz), vt[i].rmode, 1'b0);
      exp_beats = ZS ? vt[i].beats_zs : vt[i].beats_full;
      check("tbl_beats", 64'(got_d.size()), 64'(exp_beats));
      if (got_d.size() > 0)
        check("tbl_header", got_d[0], {16'hA5A5, vt[i].nz, exp_count - 32'd1});
    end

    // Held evento_valid must not retrigger; a fresh 0->1 does.
    run_frame(make_ev(64'h1000, 16'hFFFF), 0, 1'b1);
    run_frame(make_ev(64'h2000, 16'h00FF), 0, 1'b0);

    // Captures at cycles 10 and 50 after reset.
    do_reset();
    for (int k = 0; k < 100 && tb_cycles != 32'd10; k++) tick();
    check("reach_cycle10", 64'(tb_cycles), 64'(10));
    run_frame(make_ev(64'h3000, 16'hFFFF), 0, 1'b0);
    ts1 = (got_d.size() > 1) ? got_d[1][31:0] : 32'h0;
    check("hdr_id0", (got_d.size() > 0) ? 64'(got_d[0][31:0]) : 64'hX, 64'(0));
    for (int k = 0; k < 100 && tb_cycles != 32'd50; k++) tick();
    check("reach_cycle50", 64'(tb_cycles), 64'(50));
    run_frame(make_ev(64'h4000, 16'hFFFF), 0, 1'b0);
    ts2 = (got_d.size() > 1) ? got_d[1][31:0] : 32'h0;
    check("hdr_id1", (got_d.size() > 0) ? 64'(got_d[0][31:0]) : 64'hX, 64'(1));
    check("ts_delta", 64'(ts2 - ts1), 64'(40));

    // Reset while the fifth beat is on the bus.
    pk_if.evento       = make_ev(64'h1000, 16'hFFFF);
    pk_if.evento_valid = 1'b1;
    pk_if.m_tready     = 1'b1;
    nb      = 0;
    reached = 1'b0;
    for (int k = 0; k < 60 && !reached; k++) begin
      if (pk_if.m_tvalid) begin
        if (nb == 4) reached = 1'b1;
        else nb++;
      end
      if (!reached) tick();
    end
    check("abort_reach_beat5", 64'(reached), 64'(1));
    reset              = 1'b1;
    pk_if.evento_valid = 1'b0;
    tick();
    check("abort_tvalid", 64'(pk_if.m_tvalid), 64'(0));
    check("abort_tlast", 64'(pk_if.m_tlast), 64'(0));
    check("abort_count", 64'(event_count), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    reset          = 1'b0;
    pk_if.m_tready = 1'b0;
    exp_count      = '0;
    run_frame(make_ev(64'h1000, 16'hFFFF), 0, 1'b0);

    // Randomized events and back-pressure.
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      run_frame(rand_ev(i % 5 == 0), int'($urandom_range(0, 2)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
